button_conditioner: RTL

Conditions the raw active-low push buttons (start, move, select) before they reach the game controller. Each channel gets a two-flop synchronizer, a counter-based debouncer, and a one-cycle press pulse. Channels flagged in `REPEAT_MASK` also auto-repeat while held, so the cursor can scroll across board positions. Sits between the board pins and `game_controller` in the tic-tac-toe top level, clocked on the same clock as the controller.

---
 rtl/button_pkg.sv | 21 ++
 rtl/button_channel.sv | 132 +++++++++++++
 rtl/button_conditioner.sv | 35 +++
 3 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
package button_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ARMING,
      HELD,
      DISARMING
   } btn_state_t;

   localparam int BTN_START  = 0;
   localparam int BTN_MOVE   = 1;
   localparam int BTN_SELECT = 2;

   function automatic int max3(input int a, input int b, input int c);
      int m;
      m = (a > b) ? a : b;
      return (m > c) ? m : c;
   endfunction

endpackage

// File: rtl/button_channel.sv
// One button: two-flop synchronizer, debounce FSM and optional repeat timer.
module button_channel
   import button_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500_000,
   parameter int REPEAT_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD   = 10_000_000,
   parameter bit repeat_en       = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_n,
   output logic level,
   output logic press,
   output logic release_p
);

   localparam int CW =
      $clog2(max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;

   localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
   localparam logic [CW-1:0] ONE      = CW'(1);

   logic [1:0]    sync_q;
   logic          s;
   btn_state_t    state_q, state_d;
   logic [CW-1:0] deb_q, deb_d;
   logic [CW-1:0] rpt_q, rpt_d;
   logic          phase_q, phase_d;
   logic          level_d, press_d, rel_d;
   logic          rpt_tick;
   logic [CW-1:0] rpt_last;

   assign s        = sync_q[1];
   assign rpt_last = phase_q ? PER_LAST : DLY_LAST;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q    <= 2'b00;
         state_q   <= IDLE;
         deb_q     <= '0;
         rpt_q     <= '0;
         phase_q   <= 1'b0;
         level     <= 1'b0;
         press     <= 1'b0;
         release_p <= 1'b0;
      end else begin
         sync_q    <= {sync_q[0], ~btn_n};
         state_q   <= state_d;
         deb_q     <= deb_d;
         rpt_q     <= rpt_d;
         phase_q   <= phase_d;
         level     <= level_d;
         press     <= press_d;
         release_p <= rel_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      deb_d    = deb_q;
      rpt_d    = rpt_q;
      phase_d  = phase_q;
      level_d  = level;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      rpt_tick = 1'b0;

      unique case (state_q)
         IDLE: begin
            deb_d   = '0;
            rpt_d   = '0;
            phase_d = 1'b0;
            if (s) begin
               state_d = ARMING;
               deb_d   = ONE;
            end
         end
         ARMING: begin
            if (!s) begin
               state_d = IDLE;
               deb_d   = '0;
            end else if (deb_q == DEB_LAST) begin
               state_d = HELD;
               level_d = 1'b1;
               press_d = 1'b1;
               deb_d   = '0;
               rpt_d   = '0;
               phase_d = 1'b0;
            end else begin
               deb_d = deb_q + ONE;
            end
         end
         HELD: begin
            if (!s) begin
               state_d = DISARMING;
               deb_d   = ONE;
            end else begin
               rpt_tick = 1'b1;
            end
         end
         DISARMING: begin
            // a glitch back to pressed resumes the repeat cadence in place
            if (s) begin
               state_d  = HELD;
               deb_d    = '0;
               rpt_tick = 1'b1;
            end else if (deb_q == DEB_LAST) begin
               state_d = IDLE;
               level_d = 1'b0;
               rel_d   = 1'b1;
               deb_d   = '0;
            end else begin
               deb_d = deb_q + ONE;
            end
         end
      endcase

      if (repeat_en && rpt_tick) begin
         if (rpt_q == rpt_last) begin
            press_d = 1'b1;
            rpt_d   = '0;
            phase_d = 1'b1;
         end else begin
            rpt_d = rpt_q + ONE;
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Conditions N_BTN raw active-low buttons into level/press/release pulses.
module button_conditioner
   import button_pkg::*;
#(
   parameter int               N_BTN           = 3,
   parameter int               DEBOUNCE_CYCLES = 500_000,
   parameter int               REPEAT_DELAY    = 25_000_000,
   parameter int               REPEAT_PERIOD   = 10_000_000,
   parameter logic [N_BTN-1:0] REPEAT_MASK     = 3'b010
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_n,
   output logic [N_BTN-1:0] level,
   output logic [N_BTN-1:0] press,
   output logic [N_BTN-1:0] release_p
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      button_channel #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .REPEAT_DELAY   (REPEAT_DELAY),
         .REPEAT_PERIOD  (REPEAT_PERIOD),
         .repeat_en      (REPEAT_MASK[i])
      ) u_ch (
         .clk      (clk),
         .rst      (rst),
         .btn_n    (btn_n[i]),
         .level    (level[i]),
         .press    (press[i]),
         .release_p(release_p[i])
      );
   end

endmodule
